// File: rtl/jtframe_hsize_ctrl.sv
// jtframe_hsize_ctrl
// Frame-synchronous controller for the horizontal scaler configuration.
// Raw OSD requests are tracked every clock, but the applied scale/offset/
// enable only change one clock after the rising edge of vertical blank, so
// the line buffer never sees a setting switch in the middle of a frame.
// Optional ramping moves the scale one code per applied update and optional
// auto-centring derives the offset from the scale being applied.

module jtframe_hsize_ctrl #(
  parameter int CENTRE_K    = 8,   // auto-centring gain, 1..31
  parameter int HOLD_FRAMES = 1    // frames between ramp steps, 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       VB_in,
  input  logic [3:0] req_scale,
  input  logic [4:0] req_offset,
  input  logic       req_enable,
  input  logic       ramp,
  input  logic       auto_ctr,
  output logic [3:0] scale,
  output logic [4:0] offset,
  output logic       enable,
  output logic       busy
);

  // Scale code 8 is 1:1, which is also the parked value while disabled
  localparam logic [3:0]        UNITY     = 4'd8;
  localparam logic [3:0]        HOLD_INIT = 4'(HOLD_FRAMES - 1);
  localparam logic signed [10:0] GAIN     = 11'(CENTRE_K);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    APPLY,
    HOLD
  } state_t;

  state_t     state, state_nx;
  logic [3:0] hold_cnt, hold_cnt_nx;
  logic [3:0] scale_nx;
  logic [4:0] offset_nx;
  logic       enable_nx;

  logic       vb_last;
  logic       vbt;

  logic [3:0] tgt_scale;
  logic [4:0] tgt_off_now;
  logic       differs;

  logic [3:0] upd_scale;
  logic [4:0] upd_off;
  logic       upd_en;
  logic       upd_differs;

  // Centring offset for scale code s. Codes below 8 shrink the picture
  // twice as fast as codes above 8 enlarge it, hence the asymmetric summand.
  // The product is floored by the arithmetic shift and then clamped to the
  // 5-bit signed range of the offset port.
  function automatic logic [4:0] auto_offset(input logic [3:0] s);
    logic signed [5:0]  delta;
    logic signed [10:0] prod;
    logic signed [10:0] shr;
    logic [4:0]         res;
    if (s[3]) delta = {3'b000, s[2:0]};
    else      delta = {1'b0, s, 1'b1} - 6'd16;
    prod = 11'(delta) * GAIN;
    shr  = prod >>> 4;
    if (shr > 11'sd15)       res = 5'b01111;
    else if (shr < -11'sd16) res = 5'b10000;
    else                     res = shr[4:0];
    return res;
  endfunction

  // Offset the scaler should use at scale code s given the current requests;
  // a disabled target always parks the offset at zero
  function automatic logic [4:0] offset_target(input logic       en_req,
                                               input logic       use_auto,
                                               input logic [4:0] manual,
                                               input logic [3:0] s);
    logic [4:0] res;
    if (!en_req)       res = 5'd0;
    else if (use_auto) res = auto_offset(s);
    else               res = manual;
    return res;
  endfunction

  // One ramp step from cur toward tgt
  function automatic logic [3:0] step_toward(input logic [3:0] cur,
                                             input logic [3:0] tgt);
    logic [3:0] res;
    if (cur < tgt)      res = cur + 4'd1;
    else if (cur > tgt) res = cur - 4'd1;
    else                res = cur;
    return res;
  endfunction

  // Frame tick: rising edge of VB_in as seen on pixel-enable samples only
  assign vbt = pxl_cen & VB_in & ~vb_last;

  assign busy = (state != IDLE);

  // Remember the last pixel-enable sample of VB_in; resetting it high keeps
  // a blank already in progress at reset from counting as a new frame
  always_ff @(posedge clk) begin
    if (rst)          vb_last <= 1'b1;
    else if (pxl_cen) vb_last <= VB_in;
  end

  // Target settings and the candidate update that APPLY would commit
  always_comb begin
    tgt_scale   = req_enable ? req_scale : UNITY;
    tgt_off_now = offset_target(req_enable, auto_ctr, req_offset, scale);
    differs     = (scale != tgt_scale) || (offset != tgt_off_now) ||
                  (enable != req_enable);

    upd_scale = ramp ? step_toward(scale, tgt_scale) : tgt_scale;
    upd_off   = offset_target(req_enable, auto_ctr, req_offset, upd_scale);
    upd_en    = req_enable | (enable & ((upd_scale != UNITY) | (upd_off != 5'd0)));
    if (!enable && req_enable) begin
      upd_scale = UNITY;
      upd_off   = 5'd0;
      upd_en    = 1'b1;
    end

    upd_differs = (upd_scale != tgt_scale) ||
                  (upd_off != offset_target(req_enable, auto_ctr, req_offset, upd_scale)) ||
                  (upd_en != req_enable);
  end

  // Next-state logic; the applied settings only move in APPLY
  always_comb begin
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    scale_nx    = scale;
    offset_nx   = offset;
    enable_nx   = enable;
    case (state)
      IDLE: begin
        if (differs) state_nx = WAIT;
      end
      WAIT: begin
        if (!differs) state_nx = IDLE;
        else if (vbt) state_nx = APPLY;
      end
      APPLY: begin
        scale_nx  = upd_scale;
        offset_nx = upd_off;
        enable_nx = upd_en;
        if (upd_differs) begin
          state_nx    = HOLD;
          hold_cnt_nx = HOLD_INIT;
        end else begin
          state_nx = IDLE;
        end
      end
      HOLD: begin
        if (vbt) begin
          if (hold_cnt == 4'd0) state_nx = APPLY;
          else                  hold_cnt_nx = hold_cnt - 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, hold counter and applied settings registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= 4'd0;
      scale    <= UNITY;
      offset   <= 5'd0;
      enable   <= 1'b0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_cnt_nx;
      scale    <= scale_nx;
      offset   <= offset_nx;
      enable   <= enable_nx;
    end
  end

endmodule

// File: tb/tb_jtframe_hsize_ctrl.sv
// tb_jtframe_hsize_ctrl
// Three controllers share one stimulus stream: default gain/hold, gain 31,
// and a three-frame hold. A frame-level model predicts every output each
// cycle, and literal values taken from hand calculation pin the model.

module tb_jtframe_hsize_ctrl;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       pxl_cen;
  logic       VB_in;
  logic [3:0] req_scale;
  logic [4:0] req_offset;
  logic       req_enable;
  logic       ramp;
  logic       auto_ctr;

  logic [3:0] d_scale [NI];
  logic [4:0] d_off   [NI];
  logic       d_en    [NI];
  logic       d_busy  [NI];

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  int par_k [NI] = '{8, 31, 8};
  int par_h [NI] = '{1, 1, 3};

  int m_scale [NI];
  int m_off   [NI];
  int m_wait  [NI];
  bit m_en    [NI];
  bit m_pend  [NI];
  bit m_due   [NI];
  bit m_first [NI];
  bit m_last  [NI];

  int h3_tab [8] = '{7, 7, 7, 6, 6, 6, 5, 5};

  always #5 clk = ~clk;

  jtframe_hsize_ctrl #(.CENTRE_K(8), .HOLD_FRAMES(1)) u_def (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .VB_in(VB_in),
    .req_scale(req_scale), .req_offset(req_offset), .req_enable(req_enable),
    .ramp(ramp), .auto_ctr(auto_ctr),
    .scale(d_scale[0]), .offset(d_off[0]), .enable(d_en[0]), .busy(d_busy[0])
  );

  jtframe_hsize_ctrl #(.CENTRE_K(31), .HOLD_FRAMES(1)) u_k31 (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .VB_in(VB_in),
    .req_scale(req_scale), .req_offset(req_offset), .req_enable(req_enable),
    .ramp(ramp), .auto_ctr(auto_ctr),
    .scale(d_scale[1]), .offset(d_off[1]), .enable(d_en[1]), .busy(d_busy[1])
  );

  jtframe_hsize_ctrl #(.CENTRE_K(8), .HOLD_FRAMES(3)) u_h3 (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .VB_in(VB_in),
    .req_scale(req_scale), .req_offset(req_offset), .req_enable(req_enable),
    .ramp(ramp), .auto_ctr(auto_ctr),
    .scale(d_scale[2]), .offset(d_off[2]), .enable(d_en[2]), .busy(d_busy[2])
  );

  function automatic int sext5(logic [4:0] v);
    return v[4] ? int'(v) - 32 : int'(v);
  endfunction

  // Centring offset from plain integer arithmetic with explicit floor division
  function automatic int auto_model(int s, int k);
    int d, p, q;
    d = (s < 8) ? (2 * s + 1) - 16 : (16 + (s - 8)) - 16;
    p = d * k;
    q = (p >= 0) ? p / 16 : -((-p + 15) / 16);
    if (q > 15)  q = 15;
    if (q < -16) q = -16;
    return q;
  endfunction

  function automatic int tgt_off_model(int s, int k);
    if (!req_enable) return 0;
    if (auto_ctr)    return auto_model(s, k);
    return sext5(req_offset);
  endfunction

  function automatic bit model_differs(int i);
    int ts;
    ts = req_enable ? int'(req_scale) : 8;
    return (m_scale[i] != ts) || (m_off[i] != tgt_off_model(m_scale[i], par_k[i])) ||
           (m_en[i] != req_enable);
  endfunction

  // Advance one model by one clock using the inputs present at this edge
  task automatic model_step(int i);
    bit tick, e_new;
    int s_new, o_new, ts;
    if (rst) begin
      m_scale[i] = 8; m_off[i] = 0; m_en[i] = 0;
      m_pend[i] = 0; m_due[i] = 0; m_first[i] = 0; m_wait[i] = 0; m_last[i] = 1;
    end else begin
      tick = pxl_cen && VB_in && !m_last[i];
      if (pxl_cen) m_last[i] = VB_in;
      if (m_due[i]) begin
        m_due[i] = 0;
        ts = req_enable ? int'(req_scale) : 8;
        if (!m_en[i] && req_enable) begin
          s_new = 8; o_new = 0; e_new = 1;
        end else begin
          if (!ramp)                s_new = ts;
          else if (m_scale[i] < ts) s_new = m_scale[i] + 1;
          else if (m_scale[i] > ts) s_new = m_scale[i] - 1;
          else                      s_new = m_scale[i];
          o_new = tgt_off_model(s_new, par_k[i]);
          e_new = req_enable || (m_en[i] && !(s_new == 8 && o_new == 0));
        end
        m_scale[i] = s_new; m_off[i] = o_new; m_en[i] = e_new;
        if (model_differs(i)) begin
          m_pend[i] = 1; m_first[i] = 0; m_wait[i] = par_h[i] - 1;
        end else begin
          m_pend[i] = 0;
        end
      end else if (!m_pend[i]) begin
        if (model_differs(i)) begin
          m_pend[i] = 1; m_first[i] = 1;
        end
      end else if (m_first[i]) begin
        if (!model_differs(i)) m_pend[i] = 0;
        else if (tick)         m_due[i] = 1;
      end else if (tick) begin
        if (m_wait[i] == 0) m_due[i] = 1;
        else                m_wait[i] = m_wait[i] - 1;
      end
    end
  endtask

  task automatic checkOutput(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(logic en, logic [3:0] sc, logic [4:0] of, logic rmp, logic ac);
    @(negedge clk);
    req_enable = en;
    req_scale  = sc;
    req_offset = of;
    ramp       = rmp;
    auto_ctr   = ac;
  endtask

  // One frame: blank low for a few clocks, then a rising edge that stays high
  task automatic runFrame();
    @(negedge clk);
    VB_in = 1'b0;
    repeat (3) @(negedge clk);
    VB_in = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic runFrames(int n);
    for (int f = 0; f < n; f++) runFrame();
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) model_step(i);
  end

  // Every cycle, every instance against its model
  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < NI; i++) begin
        checkOutput($sformatf("model scale[%0d]", i), int'(d_scale[i]), m_scale[i]);
        checkOutput($sformatf("model offset[%0d]", i), sext5(d_off[i]), m_off[i]);
        checkOutput($sformatf("model enable[%0d]", i), int'(d_en[i]), int'(m_en[i]));
        checkOutput($sformatf("model busy[%0d]", i), int'(d_busy[i]), int'(m_pend[i] || m_due[i]));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; pxl_cen = 1'b1; VB_in = 1'b1;
    req_enable = 1'b0; req_scale = 4'd8; req_offset = 5'd0; ramp = 1'b0; auto_ctr = 1'b0;
    @(posedge clk);
    check_en = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset scale", int'(d_scale[0]), 8);
    checkOutput("reset offset", sext5(d_off[0]), 0);
    checkOutput("reset enable", int'(d_en[0]), 0);
    checkOutput("reset busy", int'(d_busy[0]), 0);
    rst = 1'b0;

    // Turn on at 1:1; VB_in high since reset must not count as a frame
    applyStimulus(1'b1, 4'd8, 5'd0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("enable before tick", int'(d_en[0]), 0);
    checkOutput("busy before tick", int'(d_busy[0]), 1);
    runFrame();
    checkOutput("turn-on enable", int'(d_en[0]), 1);
    checkOutput("turn-on scale", int'(d_scale[0]), 8);
    checkOutput("turn-on busy", int'(d_busy[0]), 0);

    // Ramp 8 -> 0 with auto-centring
    applyStimulus(1'b1, 4'd0, 5'd0, 1'b1, 1'b1);
    for (int f = 1; f <= 8; f++) begin
      if (f == 4) begin
        @(negedge clk);
        pxl_cen = 1'b0;
        VB_in = 1'b0;
        repeat (2) @(negedge clk);
        VB_in = 1'b1;
        repeat (2) @(negedge clk);
        pxl_cen = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("no tick without pxl_cen", int'(d_scale[0]), 5);
      end
      runFrame();
      checkOutput($sformatf("ramp down scale f%0d", f), int'(d_scale[0]), 8 - f);
      checkOutput($sformatf("hold3 scale f%0d", f), int'(d_scale[2]), h3_tab[f-1]);
      if (f == 1) checkOutput("auto offset s7", sext5(d_off[0]), -1);
    end
    checkOutput("auto offset s0", sext5(d_off[0]), -8);
    checkOutput("auto offset s0 k31", sext5(d_off[1]), -16);
    checkOutput("ramp down busy", int'(d_busy[0]), 0);

    // Direct jump to 15
    applyStimulus(1'b1, 4'd15, 5'd0, 1'b0, 1'b1);
    runFrame();
    checkOutput("jump scale", int'(d_scale[0]), 15);
    checkOutput("auto offset s15", sext5(d_off[0]), 3);
    checkOutput("auto offset s15 k31", sext5(d_off[1]), 13);
    checkOutput("jump busy", int'(d_busy[0]), 0);
    runFrames(2);

    // Back to 0, then ramp the turn-off up to 1:1
    applyStimulus(1'b1, 4'd0, 5'd0, 1'b0, 1'b1);
    runFrames(2);
    applyStimulus(1'b0, 4'd0, 5'd0, 1'b1, 1'b1);
    for (int f = 1; f <= 8; f++) begin
      runFrame();
      checkOutput($sformatf("turn-off scale f%0d", f), int'(d_scale[0]), f);
      checkOutput($sformatf("turn-off enable f%0d", f), int'(d_en[0]), (f < 8) ? 1 : 0);
      checkOutput($sformatf("turn-off offset f%0d", f), sext5(d_off[0]), 0);
    end
    checkOutput("turn-off busy", int'(d_busy[0]), 0);
    runFrames(15);
    checkOutput("hold3 turn-off scale", int'(d_scale[2]), 8);
    checkOutput("hold3 turn-off enable", int'(d_en[2]), 0);

    // Reset in the middle of a ramp
    applyStimulus(1'b1, 4'd0, 5'd0, 1'b1, 1'b1);
    runFrames(5);
    checkOutput("pre-reset scale", int'(d_scale[0]), 4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid-ramp reset scale", int'(d_scale[0]), 8);
    checkOutput("mid-ramp reset offset", sext5(d_off[0]), 0);
    checkOutput("mid-ramp reset enable", int'(d_en[0]), 0);
    checkOutput("mid-ramp reset busy", int'(d_busy[0]), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("post-reset no tick enable", int'(d_en[0]), 0);
    checkOutput("post-reset busy", int'(d_busy[0]), 1);
    runFrame();
    checkOutput("post-reset turn-on", int'(d_en[0]), 1);

    applyStimulus(1'b0, 4'd8, 5'd0, 1'b0, 1'b0);
    runFrames(2);
    checkOutput("final enable", int'(d_en[0]), 0);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
